spi_arbiter: RTL and testbench

SPI_ARBITER -- requirements
Module: spi_arbiter

---
 rtl/spi_arb_pkg.sv | 23 ++
 rtl/spi_arbiter_if.sv | 40 ++++
 rtl/spi_rr_arb2.sv | 27 ++
 rtl/spi_arbiter.sv | 119 +++++++++++
 tb/tb_spi_arbiter.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_arb_pkg.sv
// Shared definitions for the two-requester SPI command arbiter.
//   NUM_REQ     : number of requesters sharing the spi_master
//   TIMEOUT_DEF : default per-phase cycle budget before a transaction aborts
//   state_t     : FSM state encoding (IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, RESP)
//   depth_ok()  : a granted bit count is usable only if 1..data width
package spi_arb_pkg;

  localparam int unsigned NUM_REQ     = 2;
  localparam int unsigned TIMEOUT_DEF = 4096;

  typedef logic [2:0] state_t;

  localparam state_t IDLE      = 3'd0;
  localparam state_t LAUNCH    = 3'd1;
  localparam state_t WAIT_BUSY = 3'd2;
  localparam state_t WAIT_DONE = 3'd3;
  localparam state_t RESP      = 3'd4;

  function automatic logic depth_ok(input logic [7:0] depth, input int unsigned width);
    return (depth != 8'd0) && (32'(depth) <= width);
  endfunction

endpackage

// File: rtl/spi_arbiter_if.sv
// Bundle of requester handshake, response and spi_master command/status signals.
//   req_valid/req_dir/req_depth/req_data : per-requester command (towards arbiter)
//   req_ready/rsp_valid                  : one-hot accept / completion pulses
//   rsp_err/rsp_data                     : response, qualified by rsp_valid
//   m_start/m_dir/m_depth/m_tx           : command to spi_master
//   m_ready/m_read_finish/m_rx           : status from spi_master
// Modport slave is the arbiter's view, master is the environment's view.
interface spi_arbiter_if
  import spi_arb_pkg::*;
#(
  parameter int unsigned DATA_W = 6
);

  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0]             req_dir;
  logic [NUM_REQ-1:0][7:0]        req_depth;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]             req_ready;
  logic [NUM_REQ-1:0]             rsp_valid;
  logic                           rsp_err;
  logic [DATA_W-1:0]              rsp_data;
  logic                           m_start;
  logic                           m_dir;
  logic [7:0]                     m_depth;
  logic [DATA_W-1:0]              m_tx;
  logic                           m_ready;
  logic                           m_read_finish;
  logic [DATA_W-1:0]              m_rx;

  modport slave (
    input  req_valid, req_dir, req_depth, req_data, m_ready, m_read_finish, m_rx,
    output req_ready, rsp_valid, rsp_err, rsp_data, m_start, m_dir, m_depth, m_tx
  );

  modport master (
    output req_valid, req_dir, req_depth, req_data, m_ready, m_read_finish, m_rx,
    input  req_ready, rsp_valid, rsp_err, rsp_data, m_start, m_dir, m_depth, m_tx
  );

endinterface

// File: rtl/spi_rr_arb2.sv
// Two-way round-robin selector.
//   clk, rst_n : clock, asynchronous active-low reset
//   req_i      : request vector
//   advance_i  : a grant is being taken this cycle; remember who won
//   grant_o    : one-hot grant (zero when nobody requests)
// The last-grant register resets to 1 so requester 0 wins the first contest.
module spi_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  output logic [1:0] grant_o
);

  logic last_q;

  always_comb begin
    grant_o = req_i;
    if (req_i == 2'b11) grant_o = last_q ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      last_q <= 1'b1;
    else if (advance_i && |req_i)    last_q <= grant_o[1];
  end

endmodule

// File: rtl/spi_arbiter.sv
// Arbitrates two command requesters onto a single spi_master.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : spi_arbiter_if.slave (requester handshake + spi_master link)
// Parameters: DATA_W payload width, TIMEOUT cycles allowed per SPI phase.
// Flow: IDLE grants and latches a command; illegal depths go straight to RESP
// with an error; otherwise LAUNCH -> WAIT_BUSY -> WAIT_DONE track m_ready and
// RESP emits a one-cycle completion pulse to the granted requester.
module spi_arbiter
  import spi_arb_pkg::*;
#(
  parameter int unsigned DATA_W  = 6,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  spi_arbiter_if.slave bus
);

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic              g_q;
  logic              dir_q;
  logic [7:0]        depth_q;
  logic [DATA_W-1:0] tx_q;
  logic [DATA_W-1:0] rx_q;
  logic              err_q;
  logic [15:0]       cnt_q;
  logic              rf_q;
  logic [1:0]        req_ready_q;

  logic [1:0] grant;
  logic       gidx;
  logic       take;
  logic       active;
  logic       timeout;
  logic       tmo_hit;
  logic       rf_rise;

  assign take    = (state_q == IDLE) && (|bus.req_valid);
  assign gidx    = grant[1];
  assign active  = (state_q == LAUNCH) || (state_q == WAIT_BUSY) || (state_q == WAIT_DONE);
  assign timeout = (cnt_q == TMO_LAST);
  // m_read_finish is a multi-cycle level; only its rising edge is meaningful.
  assign rf_rise = bus.m_read_finish && !rf_q;

  spi_rr_arb2 u_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (bus.req_valid),
    .advance_i (take),
    .grant_o   (grant)
  );

  always_comb begin
    state_d = state_q;
    tmo_hit = 1'b0;
    case (state_q)
      IDLE: begin
        if (take) state_d = depth_ok(bus.req_depth[gidx], DATA_W) ? LAUNCH : RESP;
      end
      LAUNCH: begin
        if (bus.m_ready)  state_d = WAIT_BUSY;
        else if (timeout) begin state_d = RESP; tmo_hit = 1'b1; end
      end
      WAIT_BUSY: begin
        if (!bus.m_ready) state_d = WAIT_DONE;
        else if (timeout) begin state_d = RESP; tmo_hit = 1'b1; end
      end
      WAIT_DONE: begin
        if (bus.m_ready)  state_d = RESP;
        else if (timeout) begin state_d = RESP; tmo_hit = 1'b1; end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      g_q         <= 1'b0;
      dir_q       <= 1'b0;
      depth_q     <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      rf_q        <= 1'b0;
      req_ready_q <= '0;
    end else begin
      state_q     <= state_d;
      rf_q        <= bus.m_read_finish;
      req_ready_q <= take ? grant : 2'b00;
      cnt_q       <= ((state_d != state_q) || !active) ? '0 : cnt_q + 16'd1;
      if (take) begin
        g_q     <= gidx;
        dir_q   <= bus.req_dir[gidx];
        depth_q <= bus.req_depth[gidx];
        tx_q    <= bus.req_data[gidx];
        rx_q    <= '0;
        err_q   <= !depth_ok(bus.req_depth[gidx], DATA_W);
      end else if (active) begin
        if ((rf_rise && !dir_q) || tmo_hit) err_q <= 1'b1;
        if ((state_q == WAIT_DONE) && bus.m_ready && dir_q) rx_q <= bus.m_rx;
      end
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = (state_q == RESP) ? {g_q, !g_q} : 2'b00;
  assign bus.rsp_err   = err_q;
  assign bus.rsp_data  = rx_q;
  assign bus.m_start   = (state_q == LAUNCH);
  assign bus.m_dir     = dir_q;
  assign bus.m_depth   = depth_q;
  assign bus.m_tx      = tx_q;

endmodule

// File: tb/tb_spi_arbiter.sv
// Directed + randomized bench for spi_arbiter with a behavioural spi_master.
module tb_spi_arbiter;

  localparam int unsigned DW  = 6;
  localparam int unsigned TMO = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  spi_arbiter_if #(.DATA_W(DW)) bus ();

  spi_arbiter #(.DATA_W(DW), .TIMEOUT(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // spi_master emulation knobs
  int            busy_len   = 4;
  bit            hang       = 1'b0;
  bit            force_rf   = 1'b0;
  logic [DW-1:0] reply_mask = 6'h3F;

  bit            mbusy = 1'b0;
  int            mcnt  = 0;
  int            rfc   = 0;
  logic [DW-1:0] ltx   = '0;
  logic          ldir  = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      bus.m_ready       <= 1'b1;
      bus.m_read_finish <= 1'b0;
      bus.m_rx          <= '0;
      mbusy = 1'b0; mcnt = 0; rfc = 0;
    end else begin
      if (rfc > 0) begin
        rfc--;
        if (rfc == 0) bus.m_read_finish <= 1'b0;
      end
      if (!mbusy) begin
        if (bus.m_start && bus.m_ready) begin
          mbusy = 1'b1; mcnt = 0; ldir = bus.m_dir; ltx = bus.m_tx;
          bus.m_ready <= 1'b0;
        end
      end else begin
        mcnt++;
        if ((mcnt == busy_len - 1) && (ldir || force_rf)) begin
          bus.m_read_finish <= 1'b1; rfc = 3;
        end
        if ((mcnt >= busy_len) && !hang) begin
          mbusy = 1'b0;
          bus.m_ready <= 1'b1;
          bus.m_rx    <= ltx ^ reply_mask;
        end
      end
    end
  end

  int rr_last = 1;
  int glog[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic dir, input int depth, input logic [DW-1:0] data);
    bus.req_dir[i]   = dir;
    bus.req_depth[i] = 8'(depth);
    bus.req_data[i]  = data;
    bus.req_valid[i] = 1'b1;
  endtask

  // Runs cycles until every posted request has been granted and answered.
  task automatic serve(input string tag, input int unsigned budget);
    int unsigned n, gc, sc;
    int g;
    bit drop, cur, cbad, chang, launched, bad, eerr, echk;
    logic edir;
    logic [7:0] edepth;
    logic [DW-1:0] etx, edata;
    n = 0; gc = 0; sc = 0; g = 0;
    cur = 0; cbad = 0; chang = 0; launched = 0; eerr = 0; echk = 0;
    edir = 0; edepth = '0; etx = '0; edata = '0;
    while (((bus.req_valid != 2'b00) || cur) && (n < budget)) begin
      @(negedge clk);
      n++;
      drop = 0;
      if (bus.req_ready != 2'b00) begin
        if (bus.req_valid == 2'b11) g = 1 - rr_last;
        else if (bus.req_valid[0])  g = 0;
        else                        g = 1;
        chk({tag, ":grant"}, 32'(bus.req_ready), 32'(1) << g);
        chk({tag, ":overlap"}, 32'(cur), 32'd0);
        rr_last = g; glog.push_back(g);
        cur = 1; launched = 0; gc = cyc; drop = 1;
        edir = bus.req_dir[g]; edepth = bus.req_depth[g]; etx = bus.req_data[g];
        bad   = (edepth == 8'd0) || (int'(edepth) > int'(DW));
        eerr  = bad || hang || (!edir && force_rf);
        echk  = !hang;
        edata = (!eerr && edir) ? (etx ^ reply_mask) : '0;
        cbad = bad; chang = hang;
      end
      if (bus.m_start) begin
        chk({tag, ":start_legal"}, 32'(cur && !cbad), 32'd1);
        chk({tag, ":m_tx"}, 32'(bus.m_tx), 32'(etx));
        chk({tag, ":m_depth"}, 32'(bus.m_depth), 32'(edepth));
        chk({tag, ":m_dir"}, 32'(bus.m_dir), 32'(edir));
        if (bus.m_ready) begin
          chk({tag, ":one_launch"}, 32'(launched), 32'd0);
          launched = 1; sc = cyc;
        end
      end else if (cur && launched && (bus.rsp_valid == 2'b00)) begin
        chk({tag, ":hold_tx"}, 32'(bus.m_tx), 32'(etx));
        chk({tag, ":hold_depth"}, 32'(bus.m_depth), 32'(edepth));
      end
      if (bus.rsp_valid != 2'b00) begin
        chk({tag, ":rsp_expected"}, 32'(cur), 32'd1);
        chk({tag, ":rsp_idx"}, 32'(bus.rsp_valid), 32'(1) << g);
        chk({tag, ":rsp_err"}, 32'(bus.rsp_err), 32'(eerr));
        if (echk) chk({tag, ":rsp_data"}, 32'(bus.rsp_data), 32'(edata));
        if (cbad) begin
          chk({tag, ":bad_latency"}, 32'((cyc - gc) <= 3), 32'd1);
          chk({tag, ":bad_nostart"}, 32'(launched), 32'd0);
        end else begin
          chk({tag, ":launched"}, 32'(launched), 32'd1);
        end
        if (chang) chk({tag, ":tmo_latency"}, 32'(cyc - sc), 32'd18);
        cur = 0;
      end
      @(posedge clk);
      #1;
      if (drop) bus.req_valid[g] = 1'b0;
    end
    chk({tag, ":done"}, 32'((bus.req_valid == 2'b00) && !cur), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    rst_n = 1'b0;
    bus.req_valid = 2'b11;
    bus.req_dir   = '0;
    bus.req_depth = '0;
    bus.req_data  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset:req_ready", 32'(bus.req_ready), 32'd0);
    chk("reset:rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("reset:m_start", 32'(bus.m_start), 32'd0);
    chk("reset:rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("reset:rsp_data", 32'(bus.rsp_data), 32'd0);
    chk("reset:m_tx", 32'(bus.m_tx), 32'd0);
    bus.req_valid = 2'b00;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // requester 0 write
    set_req(0, 1'b0, 6, 6'h2A);
    serve("wr0", 200);
    // requester 1 read, returned word 2A^3F = 15
    set_req(1, 1'b1, 6, 6'h2A);
    serve("rd1", 200);
    chk("rd1:first_grant", 32'(glog[glog.size()-1]), 32'd1);

    // simultaneous requests, three rounds
    glog.delete();
    for (int r = 0; r < 3; r++) begin
      set_req(0, r[0], 6, 6'(r + 5));
      set_req(1, !r[0], 5, 6'(r + 9));
      serve("both", 300);
    end
    chk("rr:count", 32'(glog.size()), 32'd6);
    if (glog.size() >= 3) begin
      chk("rr:g0", 32'(glog[0]), 32'd0);
      chk("rr:g1", 32'(glog[1]), 32'd1);
      chk("rr:g2", 32'(glog[2]), 32'd0);
    end

    // illegal depths
    set_req(0, 1'b0, 0, 6'h11);
    serve("depth0", 50);
    set_req(1, 1'b1, 7, 6'h22);
    serve("depth7", 50);

    // write with a spurious read_finish edge
    force_rf = 1'b1;
    set_req(0, 1'b0, 4, 6'h0F);
    serve("wr_rf", 200);
    force_rf = 1'b0;

    // spi_master never returns ready
    hang = 1'b1;
    set_req(1, 1'b1, 6, 6'h33);
    serve("timeout", 200);
    hang = 1'b0;
    set_req(0, 1'b1, 3, 6'h07);
    serve("after_tmo", 200);

    // randomized traffic
    for (int k = 0; k < 40; k++) begin
      int unsigned mask;
      mask       = $urandom_range(1, 3);
      busy_len   = $urandom_range(2, 8);
      force_rf   = ($urandom_range(0, 3) == 0);
      reply_mask = 6'($urandom);
      for (int i = 0; i < 2; i++)
        if (mask[i]) set_req(i, 1'($urandom), $urandom_range(0, 8), 6'($urandom));
      serve("rand", 300);
    end
    force_rf = 1'b0; busy_len = 4; reply_mask = 6'h3F;

    // reset in WAIT_DONE
    hang = 1'b1;
    set_req(0, 1'b1, 6, 6'h2A);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (bus.req_ready != 2'b00) begin
        rr_last = 0;
      end
      if (bus.m_start && bus.m_ready) seen = 1'b1;
    end
    chk("rst:launch_seen", 32'(seen), 32'd1);
    bus.req_valid = 2'b00;
    @(negedge clk);
    @(negedge clk);
    chk("rst:pre_dir", 32'(bus.m_dir), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst:req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst:rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst:rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("rst:rsp_data", 32'(bus.rsp_data), 32'd0);
    chk("rst:m_start", 32'(bus.m_start), 32'd0);
    chk("rst:m_dir", 32'(bus.m_dir), 32'd0);
    chk("rst:m_depth", 32'(bus.m_depth), 32'd0);
    chk("rst:m_tx", 32'(bus.m_tx), 32'd0);
    hang = 1'b0;
    rr_last = 1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("rst:no_rsp", 32'(bus.rsp_valid), 32'd0);
    end
    glog.delete();
    set_req(0, 1'b0, 6, 6'h3C);
    set_req(1, 1'b1, 2, 6'h01);
    serve("post_rst", 300);
    if (glog.size() > 0) chk("post_rst:first", 32'(glog[0]), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
